pitch_tracker: RTL and testbench

//  Upstream of the ball sprite: turns the mic sample stream into the 16-bit frequency word (Hz) the sprite

---
 rtl/pitch_pkg.sv | 25 ++
 rtl/zero_cross_detector.sv | 70 +++++++
 rtl/pitch_tracker.sv | 107 ++++++++++
 tb/tb_pitch_tracker.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pitch_pkg.sv
// Shared definitions for the pitch tracker.
//   xing_state_t : hysteretic zero-crossing state (negative / positive half-wave)
//   FREQ_W       : width of the published frequency word (Hz)
//   sat_abs()    : magnitude of a sign-extended sample, saturated so that the
//                  most negative code maps to the largest positive code
package pitch_pkg;

  localparam int FREQ_W = 16;

  typedef enum logic {
    XS_NEG = 1'b0,
    XS_POS = 1'b1
  } xing_state_t;

  // s is the sample already sign-extended to 32 bits; w is the original sample
  // width. |-2^(w-1)| does not fit in w-1 magnitude bits, so it clips to 2^(w-1)-1.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] s, input int unsigned w);
    logic [31:0] lim;
    logic [31:0] mag;
    lim = (32'd1 << (w - 1)) - 32'd1;
    mag = s[31] ? 32'(-s) : 32'(s);
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/zero_cross_detector.sv
// Hysteretic rising zero-crossing counter plus peak-magnitude tracker.
//   clk_in, rst_n : clock, asynchronous active-low reset
//   sample        : signed audio sample (two's complement, SAMPLE_W bits)
//   valid         : sample strobe; state only advances when high
//   clear         : window boundary; counters restart after absorbing this sample
//   crossings     : crossing count INCLUDING the current valid sample
//   peak          : peak |sample| INCLUDING the current valid sample
// Both outputs are look-ahead values so the window logic can close on the same
// edge that absorbs the final sample. The crossing state survives a clear.
module zero_cross_detector
  import pitch_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int HYST     = 256,
  parameter int CNT_W    = 13
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                valid,
  input  logic                clear,
  output logic [CNT_W-1:0]    crossings,
  output logic [SAMPLE_W-2:0] peak
);

  xing_state_t         state_reg, state_next;
  logic [CNT_W-1:0]    count_reg;
  logic [SAMPLE_W-2:0] peak_reg;
  logic signed [31:0]  s32;
  logic [31:0]         mag;
  logic                xing;

  assign s32 = 32'(signed'(sample));
  assign mag = sat_abs(s32, SAMPLE_W);

  always_comb begin
    state_next = state_reg;
    xing       = 1'b0;
    if (valid) begin
      case (state_reg)
        XS_NEG: if (s32 >= HYST) begin
          state_next = XS_POS;
          xing       = 1'b1;
        end
        XS_POS: if (s32 <= -HYST) state_next = XS_NEG;
      endcase
    end
  end

  assign crossings = count_reg + CNT_W'(xing);
  assign peak      = (valid && (mag > 32'(peak_reg))) ? mag[SAMPLE_W-2:0] : peak_reg;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= XS_NEG;
      count_reg <= '0;
      peak_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (clear) begin
        count_reg <= '0;
        peak_reg  <= '0;
      end else begin
        count_reg <= crossings;
        peak_reg  <= peak;
      end
    end
  end

endmodule

// File: rtl/pitch_tracker.sv
// Mic pitch tracker: counts hysteretic rising zero crossings over a fixed
// sample window, scales to Hz, smooths with a first-order IIR and publishes the
// result once per video frame.
//   clk_in          : system clock
//   rst_n           : asynchronous active-low reset
//   sample_in       : signed audio sample
//   sample_valid_in : one-cycle sample strobe
//   new_frame_in    : one-cycle start-of-frame strobe
//   freq_out        : smoothed frequency in Hz, updated only on new_frame_in
//   freq_valid_out  : one-cycle pulse when freq_out is written
//   silent_out      : last completed window peaked below SILENCE_THRESH
module pitch_tracker
  import pitch_pkg::*;
#(
  parameter int SAMPLE_W       = 16,
  parameter int WINDOW_SAMPLES = 6000,
  parameter int SCALE_SHIFT    = 3,
  parameter int HYST           = 256,
  parameter int SILENCE_THRESH = 512,
  parameter int ALPHA_SHIFT    = 2
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid_in,
  input  logic                new_frame_in,
  output logic [FREQ_W-1:0]   freq_out,
  output logic                freq_valid_out,
  output logic                silent_out
);

  localparam int CNT_W = $clog2(WINDOW_SAMPLES + 1);
  localparam int WIN_W = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_SAMPLES - 1);

  logic [WIN_W-1:0]        win_count_reg;
  logic                    window_end;
  logic [CNT_W-1:0]        crossings;
  logic [SAMPLE_W-2:0]     peak;
  logic [31:0]             scaled;
  logic                    silent_now;
  logic [FREQ_W-1:0]       raw_now;
  logic [FREQ_W-1:0]       raw_hz_reg;
  logic                    filt_pending_reg;
  logic [FREQ_W-1:0]       filt_reg, filt_next;
  logic signed [FREQ_W+1:0] diff, filt_sum;

  assign window_end = sample_valid_in && (win_count_reg == WIN_LAST);

  zero_cross_detector #(
    .SAMPLE_W (SAMPLE_W),
    .HYST     (HYST),
    .CNT_W    (CNT_W)
  ) u_zcd (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .sample    (sample_in),
    .valid     (sample_valid_in),
    .clear     (window_end),
    .crossings (crossings),
    .peak      (peak)
  );

  // Raw frequency of the window that closes with the current sample.
  always_comb begin
    scaled     = 32'(crossings) << SCALE_SHIFT;
    silent_now = 32'(peak) < 32'(SILENCE_THRESH);
    raw_now    = '0;
    if (!silent_now) raw_now = (scaled > 32'hFFFF) ? 16'hFFFF : scaled[FREQ_W-1:0];
  end

  // filt += (raw - filt) >>> ALPHA_SHIFT in 18-bit signed; the arithmetic shift
  // floors, so a rising input settles slightly short of raw while a falling one
  // lands on it exactly.
  always_comb begin
    diff     = $signed({2'b00, raw_hz_reg}) - $signed({2'b00, filt_reg});
    filt_sum = $signed({2'b00, filt_reg}) + (diff >>> ALPHA_SHIFT);
    if (filt_sum[FREQ_W+1])  filt_next = '0;
    else if (filt_sum[FREQ_W]) filt_next = '1;
    else                     filt_next = filt_sum[FREQ_W-1:0];
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      win_count_reg    <= '0;
      raw_hz_reg       <= '0;
      silent_out       <= 1'b0;
      filt_pending_reg <= 1'b0;
      filt_reg         <= '0;
      freq_out         <= '0;
      freq_valid_out   <= 1'b0;
    end else begin
      if (sample_valid_in) win_count_reg <= window_end ? '0 : win_count_reg + 1'b1;
      if (window_end) begin
        raw_hz_reg <= raw_now;
        silent_out <= silent_now;
      end
      filt_pending_reg <= window_end;
      if (filt_pending_reg) filt_reg <= filt_next;
      // Publishes the registered filt, so a frame strobe coincident with a
      // filter update sends the previous value.
      freq_valid_out <= new_frame_in;
      if (new_frame_in) freq_out <= filt_reg;
    end
  end

endmodule

// File: tb/tb_pitch_tracker.sv
// Self-checking bench for pitch_tracker. Two instances share the stimulus:
// dut_a with default parameters, dut_b with SCALE_SHIFT=6 (saturation case).
// A behavioural model predicts every frame publish into a per-instance
// scoreboard queue; an independent monitor compares on freq_valid_out.
module tb_pitch_tracker;

  localparam int WIN   = 6000;
  localparam int HYST  = 256;
  localparam int SIL   = 512;
  localparam int ALPHA = 2;

  typedef struct {
    logic [15:0] freq;
    logic        silent;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sample_in;
  logic        sample_valid_in;
  logic        new_frame_in;
  logic [15:0] freq_a, freq_b;
  logic        valid_a, valid_b;
  logic        silent_a, silent_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pitch_tracker dut_a (
    .clk_in          (clk),
    .rst_n           (rst_n),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .new_frame_in    (new_frame_in),
    .freq_out        (freq_a),
    .freq_valid_out  (valid_a),
    .silent_out      (silent_a)
  );

  pitch_tracker #(.SCALE_SHIFT(6)) dut_b (
    .clk_in          (clk),
    .rst_n           (rst_n),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .new_frame_in    (new_frame_in),
    .freq_out        (freq_b),
    .freq_valid_out  (valid_b),
    .silent_out      (silent_b)
  );

  // ---------------- reference model ----------------
  exp_t q0[$];
  exp_t q1[$];
  int   m_filt[2], m_raw[2], m_cnt[2], m_xc[2], m_peak[2];
  bit   m_pos[2], m_pend[2], m_sil[2];

  task automatic model_edge(input int i);
    int   pub, s, a, sh;
    exp_t e;
    sh  = (i == 0) ? 3 : 6;
    pub = m_filt[i];
    if (m_pend[i]) begin
      m_filt[i] = m_filt[i] + ((m_raw[i] - m_filt[i]) >>> ALPHA);
      if (m_filt[i] < 0) m_filt[i] = 0;
      if (m_filt[i] > 65535) m_filt[i] = 65535;
      m_pend[i] = 0;
    end
    if (sample_valid_in) begin
      s = int'($signed(sample_in));
      a = (s < 0) ? -s : s;
      if (a > 32767) a = 32767;
      if (a > m_peak[i]) m_peak[i] = a;
      if (!m_pos[i] && s >= HYST) begin
        m_pos[i] = 1;
        m_xc[i]++;
      end else if (m_pos[i] && s <= -HYST) begin
        m_pos[i] = 0;
      end
      m_cnt[i]++;
      if (m_cnt[i] == WIN) begin
        m_sil[i] = (m_peak[i] < SIL);
        m_raw[i] = m_xc[i] << sh;
        if (m_raw[i] > 65535) m_raw[i] = 65535;
        if (m_sil[i]) m_raw[i] = 0;
        m_pend[i] = 1;
        m_cnt[i]  = 0;
        m_xc[i]   = 0;
        m_peak[i] = 0;
      end
    end
    if (new_frame_in) begin
      e.freq   = 16'(pub);
      e.silent = m_sil[i];
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_filt[i] = 0; m_raw[i] = 0; m_cnt[i] = 0; m_xc[i] = 0; m_peak[i] = 0;
        m_pos[i] = 0;  m_pend[i] = 0; m_sil[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_edge(i);
    end
  end

  // ---------------- monitor ----------------
  int rd0 = 0;
  int rd1 = 0;

  task automatic mon_one(input int idx, input logic v, input logic [15:0] f, input logic s);
    exp_t e;
    int   avail;
    avail = (idx == 0) ? (q0.size() - rd0) : (q1.size() - rd1);
    if (v || avail > 0) begin
      checks++;
      if (avail == 0) begin
        failures++;
        $display("FAIL pub_unexpected dut%0d: got freq=%0d, required no publish", idx, f);
      end else begin
        if (idx == 0) begin e = q0[rd0]; rd0++; end
        else          begin e = q1[rd1]; rd1++; end
        if (!v) begin
          failures++;
          $display("FAIL pub_missing dut%0d: got no freq_valid_out, required freq=%0d", idx, e.freq);
        end else if (f !== e.freq || s !== e.silent) begin
          failures++;
          $display("FAIL pub_value dut%0d: got freq=%0d silent=%0b, required freq=%0d silent=%0b",
                   idx, f, s, e.freq, e.silent);
        end else begin
          $display("publish dut%0d freq=%0d silent=%0b ok", idx, f, s);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon_one(0, valid_a, freq_a, silent_a);
    mon_one(1, valid_b, freq_b, silent_b);
  end

  // ---------------- stimulus ----------------
  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end else begin
      $display("check %s = %0d ok", name, got);
    end
  endtask

  task automatic step(input logic v, input int s, input logic f);
    sample_valid_in = v;
    sample_in       = 16'(s);
    new_frame_in    = f;
    @(negedge clk);
  endtask

  function automatic int sq(input int n);
    return ((n % 48) < 24) ? 1000 : -1000;
  endfunction

  function automatic int sine(input int n);
    return $rtoi(200.0 * $sin(6.283185307 * real'(n) / 48.0));
  endfunction

  initial begin
    int exp2[3];
    int exp3[2];
    int amps[4];
    int amp, s;
    logic v, f;
    exp2 = '{250, 437, 577};
    exp3 = '{4640, 3480};
    amps = '{200, 600, 2000, 32768};
    amp  = 200;

    rst_n = 1'b0; sample_valid_in = 1'b0; sample_in = '0; new_frame_in = 1'b0;
    repeat (2) @(negedge clk);

    // Reset held: samples and frame strobes must have no effect.
    for (int n = 0; n < 100; n++) step(1'b1, sq(n), (n % 25) == 0);
    check("rst_freq_a", int'(freq_a), 0);
    check("rst_valid_a", int'(valid_a), 0);
    check("rst_silent_a", int'(silent_a), 0);
    check("rst_freq_b", int'(freq_b), 0);
    rst_n = 1'b1;
    step(1'b0, 0, 1'b0);

    // 1 kHz square, three windows.
    for (int w = 0; w < 3; w++) begin
      for (int n = 0; n < WIN; n++) step(1'b1, sq(n), 1'b0);
      step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1);
      check($sformatf("sq_win%0d_freq_a", w), int'(freq_a), exp2[w]);
    end
    check("sq_silent_a", int'(silent_a), 0);

    // Frame strobe on the filter-update cycle publishes the old value.
    for (int n = 0; n < WIN; n++) step(1'b1, sq(n), 1'b0);
    step(1'b0, 0, 1'b1);
    check("coincident_old_freq_a", int'(freq_a), 577);
    step(1'b0, 0, 1'b1);
    check("coincident_next_freq_a", int'(freq_a), 682);

    // Asynchronous reset mid-window, then a clean window.
    for (int n = 0; n < 3000; n++) step(1'b1, sq(n), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_freq_a", int'(freq_a), 0);
    check("async_rst_freq_b", int'(freq_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < WIN; n++) step(1'b1, sq(n), 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    check("post_rst_freq_a", int'(freq_a), 250);
    check("post_rst_freq_b", int'(freq_b), 2000);

    // Alternating every sample: 3000 crossings, dut_b saturates raw_hz.
    for (int n = 0; n < WIN; n++) step(1'b1, (n % 2 == 0) ? 1000 : -1000, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    check("alt_freq_a", int'(freq_a), 6187);
    check("sat_freq_b", int'(freq_b), 17883);

    // Quiet sine: no crossings, silent, filter decays.
    for (int w = 0; w < 2; w++) begin
      for (int n = 0; n < WIN; n++) step(1'b1, sine(n), 1'b0);
      step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1);
      check($sformatf("quiet_win%0d_freq_a", w), int'(freq_a), exp3[w]);
      check($sformatf("quiet_win%0d_silent_a", w), int'(silent_a), 1);
      check($sformatf("quiet_win%0d_silent_b", w), int'(silent_b), 1);
    end

    // Random amplitudes, sample gaps and frame strobes against the model.
    for (int k = 0; k < 8000; k++) begin
      if (k % 100 == 0) amp = amps[$urandom_range(0, 3)];
      v = ($urandom_range(0, 3) != 0);
      s = int'($urandom_range(0, 2 * amp - 1)) - amp;
      f = ($urandom_range(0, 199) == 0);
      step(v, s, f);
    end
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    repeat (4) step(1'b0, 0, 1'b0);

    check("scoreboard_drained_a", q0.size() - rd0, 0);
    check("scoreboard_drained_b", q1.size() - rd1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
